// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: binary-angle constants, pipeline latency, dither LFSR constants.
package cordic_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] PI(input int width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic logic [31:0] PI_2(input int width);
    return 32'd1 << (width - 2);
  endfunction

  function automatic int cordic_latency(input int iterations);
    return iterations + 1;
  endfunction

endpackage

// File: rtl/cordic_lfsr.sv
// 16-bit maximal-length Galois LFSR, advancing only on en cycles.
// Latency: new state one cycle after an en cycle.
// Backpressure: none; en simply freezes the sequence.
module cordic_lfsr
  import cordic_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/cordic_nco.sv
// Phase-accumulator NCO feeding x0/y0/z0 to a rotating-mode CORDIC; CORDIC_NCO_DITHER_EN adds LFSR phase dither.
// Latency: operands 1 cycle after an en cycle; cordic_valid a further cordic_latency(iterations) cycles.
// Backpressure: none on samples; one-deep FCW shadow, fcw_ready low until the next en cycle applies it.
module cordic_nco
  import cordic_pkg::*;
#(
  parameter int width      = 16,
  parameter int iterations = width + 2,
  parameter int acc_width  = 32
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 fcw_valid,
  output logic                 fcw_ready,
  input  logic [acc_width-1:0] fcw,
  input  logic [width-1:0]     poff,
  input  logic [width-1:0]     amp,
  output logic [width-1:0]     x0,
  output logic [width-1:0]     y0,
  output logic [width-1:0]     z0,
  output logic                 out_valid,
  output logic                 cordic_valid
);

  localparam int lat = cordic_latency(iterations);

  typedef enum logic {RUN, PEND} state_t;

  state_t               state;
  logic [acc_width-1:0] acc;
  logic [acc_width-1:0] fcw_act;
  logic [acc_width-1:0] fcw_shd;
  logic                 shd_full;
  logic [width-1:0]     phase;
  logic [lat-1:0]       vdly;

`ifdef CORDIC_NCO_DITHER_EN
  localparam int dith_bits = (acc_width - width > 16) ? 16 : acc_width - width;
  localparam logic [15:0] dith_mask = 16'((32'd1 << dith_bits) - 32'd1);

  logic [15:0]          lfsr;
  logic [acc_width-1:0] acc_d;

  cordic_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .state (lfsr)
  );

  // Dither only perturbs the truncation point; acc itself stays exact.
  assign acc_d = acc + acc_width'(lfsr & dith_mask);
  assign phase = acc_d[acc_width-1 -: width];
`else
  assign phase = acc[acc_width-1 -: width];
`endif

  assign fcw_ready = !shd_full;

  // The FCW swap in PEND happens alongside an accumulator step that still uses the old fcw_act.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fcw_act  <= '0;
      fcw_shd  <= '0;
      shd_full <= 1'b0;
    end else begin
      case (state)
        RUN: if (fcw_valid) begin
          fcw_shd  <= fcw;
          shd_full <= 1'b1;
          state    <= PEND;
        end
        PEND: if (en) begin
          fcw_act  <= fcw_shd;
          shd_full <= 1'b0;
          state    <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      x0        <= '0;
      y0        <= '0;
      z0        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        z0 <= phase + poff;
        x0 <= amp;
        y0 <= '0;
      end
      if (sync) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + fcw_act;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vdly <= '0;
    end else begin
      vdly <= {vdly[lat-2:0], out_valid};
    end
  end

  assign cordic_valid = vdly[lat-1];

endmodule

// File: tb/tb_cordic_nco.sv
// Directed plus randomized bench for cordic_nco against a phase-arithmetic reference model.
module tb_cordic_nco;

  localparam int W   = 16;
  localparam int AW  = 32;
  localparam int IT  = W + 2;
  localparam int LAT = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          sync = 1'b0;
  logic          fcw_valid = 1'b0;
  logic          fcw_ready;
  logic [AW-1:0] fcw = '0;
  logic [W-1:0]  poff = '0;
  logic [W-1:0]  amp = '0;
  logic [W-1:0]  x0, y0, z0;
  logic          out_valid, cordic_valid;

  cordic_nco #(.width(W), .iterations(IT), .acc_width(AW)) dut (
    .reset        (reset),
    .clk          (clk),
    .en           (en),
    .sync         (sync),
    .fcw_valid    (fcw_valid),
    .fcw_ready    (fcw_ready),
    .fcw          (fcw),
    .poff         (poff),
    .amp          (amp),
    .x0           (x0),
    .y0           (y0),
    .z0           (z0),
    .out_valid    (out_valid),
    .cordic_valid (cordic_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase kept as a plain integer turn fraction of 2**32.
  longint unsigned m_acc, m_fact, m_shd;
  bit              m_pend;
  logic [W-1:0]    m_x0, m_y0, m_z0;
  bit              m_ov;
  bit              m_hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_cv();
    if (m_hist.size() > LAT) return m_hist[m_hist.size() - 1 - LAT];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_fact = 0; m_shd = 0; m_pend = 0;
    m_x0 = '0; m_y0 = '0; m_z0 = '0; m_ov = 0;
    m_hist.delete();
  endtask

  task automatic model_step();
    if (en) begin
      m_z0 = W'((m_acc >> (AW - W)) + longint'(poff));
      m_x0 = amp;
      m_y0 = '0;
    end
    m_ov = en;
    if (sync) m_acc = 0;
    else if (en) m_acc = (m_acc + m_fact) & 64'hFFFF_FFFF;
    if (m_pend) begin
      if (en) begin
        m_fact = m_shd;
        m_pend = 0;
      end
    end else if (fcw_valid) begin
      m_shd  = longint'(fcw);
      m_pend = 1;
    end
    m_hist.push_back(m_ov);
    if (m_hist.size() > LAT + 1) void'(m_hist.pop_front());
  endtask

  task automatic check_all(input string tag);
`ifdef CORDIC_NCO_DITHER_EN
    logic [W-1:0] d;
    d = z0 - m_z0;
    chk({tag, ".z0_dither"}, 64'((d == 0) || (d == 1)), 64'd1);
`else
    chk({tag, ".z0"}, z0, m_z0);
`endif
    chk({tag, ".x0"}, x0, m_x0);
    chk({tag, ".y0"}, y0, m_y0);
    chk({tag, ".out_valid"}, out_valid, m_ov);
    chk({tag, ".fcw_ready"}, fcw_ready, !m_pend);
    chk({tag, ".cordic_valid"}, cordic_valid, exp_cv());
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [W-1:0] qt_exp [6];
  int           dly;
  bit           seen;

  initial begin
    qt_exp = '{16'h0000, 16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    model_reset();

    // Reset state
    do_reset();
    chk("rst_ready", fcw_ready, 1'b1);
    chk("rst_z0", z0, 16'h0000);

    // Quarter-turn FCW, loaded while stalled
    amp = 16'h4000; poff = '0;
    fcw = 32'h4000_0000; fcw_valid = 1'b1;
    cyc("qt_load");
    chk("qt_ready_low", fcw_ready, 1'b0);
    fcw_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc("qt");
      chk("qt_z0_seq", z0, qt_exp[i]);
      chk("qt_x0", x0, 16'h4000);
      if (i == 0) chk("qt_ready_back", fcw_ready, 1'b1);
    end

    // Handshake while stalled: the second offer is ignored
    en = 1'b0; fcw = 32'h8000_0000; fcw_valid = 1'b1;
    cyc("hs_first");
    chk("hs_ready_low", fcw_ready, 1'b0);
    fcw = 32'h1234_5678;
    cyc("hs_ignored");
    cyc("hs_ignored2");
    chk("hs_still_low", fcw_ready, 1'b0);
    fcw_valid = 1'b0; en = 1'b1;
    cyc("hs_apply");
    chk("hs_ready_back", fcw_ready, 1'b1);

    // Offset/wrap: clear phase, then half-turn steps alternate
    en = 1'b0; sync = 1'b1; poff = 16'h2000;
    cyc("ow_clear");
    sync = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc("ow");
      chk("ow_z0_alt", z0, (i % 2 == 0) ? 16'h2000 : 16'hA000);
    end

    // Sync with en
    en = 1'b0; fcw = 32'h1000_0000; fcw_valid = 1'b1; poff = 16'h0100;
    cyc("sy_load");
    fcw_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) cyc("sy_run");
    sync = 1'b1;
    cyc("sy_edge");
    sync = 1'b0;
    cyc("sy_next");
    chk("sy_next_z0", z0, 16'h0100);

    // en low freezes phase
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("frz");
    en = 1'b1;
    cyc("frz_resume");
    chk("frz_resume_z0", z0, 16'h1100);

    // Valid alignment on a single en pulse
    en = 1'b0;
    for (int i = 0; i < LAT + 6; i++) cyc("va_drain");
    en = 1'b1;
    cyc("va_pulse");
    chk("va_out_valid", out_valid, 1'b1);
    en = 1'b0;
    dly = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc("va_wait");
      if (cordic_valid && dly < 0) dly = i;
    end
    chk("va_cv_delay", 64'(dly), 64'(LAT));

    // Reset mid-flight drops the in-flight cordic_valid
    en = 1'b1;
    cyc("mf_pulse");
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("mf_flight");
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < LAT + 6; i++) begin
      cyc("mf_after");
      if (cordic_valid) seen = 1'b1;
    end
    chk("mf_no_cv", seen, 1'b0);
    chk("mf_ready", fcw_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom_range(0, 9) < 7);
      sync      = ($urandom_range(0, 19) == 0);
      fcw_valid = ($urandom_range(0, 4) == 0);
      fcw       = $urandom;
      poff      = W'($urandom);
      amp       = W'($urandom);
      cyc("rnd");
    end
    en = 1'b0; sync = 1'b0; fcw_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) cyc("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
